// File: rtl/rgb2ycbcr_converter_pkg.sv
// rtl/rgb2ycbcr_converter_pkg.sv - shared coefficients, FSM encoding and byte order for the RGB565 to YCbCr 4:2:2 converter
package rgb2ycbcr_converter_pkg;

  localparam int unsigned ACC_W = 20;
  typedef logic signed [ACC_W-1:0] acc_t;

  localparam acc_t Y_R     = 20'sd77;
  localparam acc_t Y_G     = 20'sd150;
  localparam acc_t Y_B     = 20'sd29;
  localparam acc_t Y_ROUND = 20'sd128;

  localparam acc_t CB_R = -20'sd43;
  localparam acc_t CB_G = -20'sd85;
  localparam acc_t CB_B = 20'sd128;

  localparam acc_t CR_R = 20'sd128;
  localparam acc_t CR_G = -20'sd107;
  localparam acc_t CR_B = -20'sd21;

  // 128 << 8 bias plus 128 rounding term
  localparam acc_t C_OFFSET = 20'sd32896;

  typedef enum logic [1:0] {
    S_P0   = 2'd0,
    S_P1   = 2'd1,
    S_CALC = 2'd2,
    S_OUT  = 2'd3
  } state_e;

  localparam logic [1:0] IDX_CB = 2'd0;
  localparam logic [1:0] IDX_Y0 = 2'd1;
  localparam logic [1:0] IDX_CR = 2'd2;
  localparam logic [1:0] IDX_Y1 = 2'd3;

  typedef struct packed {
    logic [7:0] y;
    logic [7:0] cb;
    logic [7:0] cr;
  } ycc_t;

  function automatic acc_t widen(input logic [7:0] v);
    return $signed({{(ACC_W-8){1'b0}}, v});
  endfunction

  function automatic logic [7:0] fit8(input acc_t v, input bit clamp);
    if (!clamp) return v[7:0];
    if (v < 0) return 8'h00;
    if (v > 20'sd255) return 8'hFF;
    return v[7:0];
  endfunction

endpackage

// File: rtl/rgb2ycbcr_converter_ycc.sv
// rtl/rgb2ycbcr_converter_ycc.sv - combinational per-pixel RGB565 expansion, colour matrix and clamp
module rgb565_to_ycc
  import rgb2ycbcr_converter_pkg::*;
#(
  parameter bit CLAMP_EN = 1'b1
) (
  input  logic [15:0] rgb_i,
  output ycc_t        ycc_o
);

  logic [7:0] r8, g8, b8;
  acc_t       r_s, g_s, b_s;
  acc_t       y_acc, cb_acc, cr_acc;

  always_comb begin
    // Bit replication maps full-scale 5/6-bit codes onto exactly 255
    r8 = {rgb_i[15:11], rgb_i[15:13]};
    g8 = {rgb_i[10:5],  rgb_i[10:9]};
    b8 = {rgb_i[4:0],   rgb_i[4:2]};

    r_s = widen(r8);
    g_s = widen(g8);
    b_s = widen(b8);

    y_acc  = (Y_R  * r_s + Y_G  * g_s + Y_B  * b_s + Y_ROUND)  >>> 8;
    cb_acc = (CB_R * r_s + CB_G * g_s + CB_B * b_s + C_OFFSET) >>> 8;
    cr_acc = (CR_R * r_s + CR_G * g_s + CR_B * b_s + C_OFFSET) >>> 8;

    ycc_o.y  = fit8(y_acc,  CLAMP_EN);
    ycc_o.cb = fit8(cb_acc, CLAMP_EN);
    ycc_o.cr = fit8(cr_acc, CLAMP_EN);
  end

endmodule

// File: rtl/rgb2ycbcr_converter.sv
// rtl/rgb2ycbcr_converter.sv - pairs RGB565 pixels and emits a Cb,Y0,Cr,Y1 4:2:2 byte stream
module rgb2ycbcr_converter
  import rgb2ycbcr_converter_pkg::*;
#(
  parameter bit CLAMP_EN = 1'b1
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        rgb_en,
  input  logic [15:0] rgb_data,
  output logic        rgb_ready,
  input  logic        flush,
  output logic [7:0]  ycbcr_data,
  output logic        ycbcr_data_en
);

  state_e           state_q, state_d;
  logic [1:0]       cnt_q, cnt_d;
  logic [15:0]      pix0_q, pix0_d;
  logic [15:0]      pix1_q, pix1_d;
  logic [3:0][7:0]  out_q, out_d;
  ycc_t             ycc0, ycc1;
  logic [8:0]       cb_sum, cr_sum;
  logic             accept;

  rgb565_to_ycc #(.CLAMP_EN(CLAMP_EN)) u_ycc0 (.rgb_i(pix0_q), .ycc_o(ycc0));
  rgb565_to_ycc #(.CLAMP_EN(CLAMP_EN)) u_ycc1 (.rgb_i(pix1_q), .ycc_o(ycc1));

  assign accept = rgb_en & rgb_ready;
  assign cb_sum = {1'b0, ycc0.cb} + {1'b0, ycc1.cb} + 9'd1;
  assign cr_sum = {1'b0, ycc0.cr} + {1'b0, ycc1.cr} + 9'd1;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= S_P0;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_P0:    if (accept) state_d = flush ? S_CALC : S_P1;
      S_P1:    if (accept || flush) state_d = S_CALC;
      S_CALC:  state_d = S_OUT;
      S_OUT:   if (cnt_q == 2'd3) state_d = S_P0;
      default: state_d = S_P0;
    endcase
  end

  always_comb begin
    rgb_ready     = reset_n & ((state_q == S_P0) | (state_q == S_P1));
    ycbcr_data_en = (state_q == S_OUT);
    ycbcr_data    = ycbcr_data_en ? out_q[cnt_q] : 8'h00;
  end

  // A transfer in S_P1 takes priority over flush; a flush alone duplicates pixel 0
  always_comb begin
    pix0_d = pix0_q;
    pix1_d = pix1_q;
    cnt_d  = cnt_q;
    out_d  = out_q;
    case (state_q)
      S_P0: begin
        if (accept) begin
          pix0_d = rgb_data;
          if (flush) pix1_d = rgb_data;
        end
      end
      S_P1: begin
        if (accept) pix1_d = rgb_data;
        else if (flush) pix1_d = pix0_q;
      end
      S_CALC: begin
        out_d[IDX_CB] = cb_sum[8:1];
        out_d[IDX_Y0] = ycc0.y;
        out_d[IDX_CR] = cr_sum[8:1];
        out_d[IDX_Y1] = ycc1.y;
        cnt_d         = 2'd0;
      end
      S_OUT:   cnt_d = cnt_q + 2'd1;
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      cnt_q  <= 2'd0;
      pix0_q <= 16'h0000;
      pix1_q <= 16'h0000;
      out_q  <= '0;
    end else begin
      cnt_q  <= cnt_d;
      pix0_q <= pix0_d;
      pix1_q <= pix1_d;
      out_q  <= out_d;
    end
  end

endmodule

// File: tb/tb_rgb2ycbcr_converter.sv
// tb/tb_rgb2ycbcr_converter.sv - directed and reference-model checks of the RGB565 to YCbCr 4:2:2 converter
module tb_rgb2ycbcr_converter;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        rgb_en = 1'b0;
  logic [15:0] rgb_data = 16'h0000;
  logic        flush = 1'b0;
  logic        rgb_ready;
  logic [7:0]  ycbcr_data;
  logic        ycbcr_data_en;

  int          n_checks = 0;
  int          n_fail = 0;
  int          byte_cnt = 0;
  bit          mon_on = 1'b0;
  logic [7:0]  exp_q[$];

  always #5 clock = ~clock;

  rgb2ycbcr_converter #(.CLAMP_EN(1'b1)) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .rgb_en        (rgb_en),
    .rgb_data      (rgb_data),
    .rgb_ready     (rgb_ready),
    .flush         (flush),
    .ycbcr_data    (ycbcr_data),
    .ycbcr_data_en (ycbcr_data_en)
  );

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  always @(negedge clock) begin
    if (mon_on) begin
      if (ycbcr_data_en) begin
        byte_cnt++;
        if (exp_q.size() == 0) check_eq("unexpected_byte", 32'(ycbcr_data_en), 32'd0);
        else check_eq("byte", 32'(ycbcr_data), 32'(exp_q.pop_front()));
      end else begin
        check_eq("idle_zero", 32'(ycbcr_data), 32'd0);
      end
    end
  end

  task automatic push4(input logic [7:0] b0, input logic [7:0] b1,
                       input logic [7:0] b2, input logic [7:0] b3);
    exp_q.push_back(b0);
    exp_q.push_back(b1);
    exp_q.push_back(b2);
    exp_q.push_back(b3);
  endtask

  task automatic send(input logic [15:0] px, input bit fl);
    int budget = 0;
    @(negedge clock);
    while (!rgb_ready && budget < 50) begin
      budget++;
      @(negedge clock);
    end
    if (budget >= 50) check_eq("ready_timeout", 32'(rgb_ready), 32'd1);
    rgb_en   = 1'b1;
    rgb_data = px;
    flush    = fl;
    @(posedge clock);
    #1;
    rgb_en = 1'b0;
    flush  = 1'b0;
  endtask

  task automatic drive_garbage(input bit garbage);
    if (garbage) begin
      rgb_en   = 1'b1;
      rgb_data = 16'($urandom);
    end
  endtask

  // Called just after the edge that closes a pair
  task automatic expect_timing(input bit garbage);
    @(negedge clock);
    check_eq("calc_en", 32'(ycbcr_data_en), 32'd0);
    check_eq("calc_ready", 32'(rgb_ready), 32'd0);
    drive_garbage(garbage);
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      check_eq("out_en", 32'(ycbcr_data_en), 32'd1);
      check_eq("out_ready", 32'(rgb_ready), 32'd0);
      drive_garbage(garbage);
    end
    @(negedge clock);
    check_eq("done_en", 32'(ycbcr_data_en), 32'd0);
    check_eq("done_ready", 32'(rgb_ready), 32'd1);
    rgb_en = 1'b0;
  endtask

  task automatic pair(input logic [15:0] p0, input logic [15:0] p1,
                      input logic [7:0] b0, input logic [7:0] b1,
                      input logic [7:0] b2, input logic [7:0] b3, input bit garbage);
    push4(b0, b1, b2, b3);
    send(p0, 1'b0);
    send(p1, 1'b0);
    expect_timing(garbage);
  endtask

  function automatic int sat8(input int v);
    return (v < 0) ? 0 : ((v > 255) ? 255 : v);
  endfunction

  function automatic void ycc_ref(input logic [15:0] p, output int y, output int cb, output int cr);
    int r = int'({p[15:11], p[15:13]});
    int g = int'({p[10:5], p[10:9]});
    int b = int'({p[4:0], p[4:2]});
    y  = (77 * r + 150 * g + 29 * b + 128) >>> 8;
    cb = sat8((-43 * r - 85 * g + 128 * b + 32896) >>> 8);
    cr = sat8((128 * r - 107 * g - 21 * b + 32896) >>> 8);
  endfunction

  task automatic push_model(input logic [15:0] a, input logic [15:0] b);
    int ya, cba, cra, yb, cbb, crb;
    ycc_ref(a, ya, cba, cra);
    ycc_ref(b, yb, cbb, crb);
    push4(8'((cba + cbb + 1) >>> 1), 8'(ya), 8'((cra + crb + 1) >>> 1), 8'(yb));
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] px, pend;
    int          start_cnt;
    int          budget;

    repeat (3) @(negedge clock);
    check_eq("reset_ready", 32'(rgb_ready), 32'd0);
    check_eq("reset_en", 32'(ycbcr_data_en), 32'd0);
    check_eq("reset_data", 32'(ycbcr_data), 32'd0);
    mon_on  = 1'b1;
    reset_n = 1'b1;
    @(negedge clock);
    check_eq("release_ready", 32'(rgb_ready), 32'd1);

    pair(16'hFFFF, 16'hFFFF, 8'h80, 8'hFF, 8'h80, 8'hFF, 1'b0);
    pair(16'h0000, 16'h0000, 8'h80, 8'h00, 8'h80, 8'h00, 1'b0);
    pair(16'hF800, 16'h001F, 8'hAA, 8'h4D, 8'hB5, 8'h1D, 1'b0);
    pair(16'h07E0, 16'hFFFF, 8'h56, 8'h95, 8'h4B, 8'hFF, 1'b1);

    push4(8'h55, 8'h4D, 8'hFF, 8'h4D);
    send(16'hF800, 1'b0);
    @(negedge clock);
    flush = 1'b1;
    @(posedge clock);
    #1;
    flush = 1'b0;
    expect_timing(1'b0);

    start_cnt = byte_cnt;
    @(negedge clock);
    flush = 1'b1;
    repeat (3) @(negedge clock);
    flush = 1'b0;
    repeat (8) @(negedge clock);
    check_eq("flush_idle_bytes", 32'(byte_cnt), 32'(start_cnt));
    check_eq("flush_idle_ready", 32'(rgb_ready), 32'd1);

    push4(8'h2B, 8'h95, 8'h15, 8'h95);
    send(16'h07E0, 1'b1);
    expect_timing(1'b0);

    exp_q.push_back(8'h56);
    exp_q.push_back(8'h95);
    exp_q.push_back(8'h4B);
    send(16'h07E0, 1'b0);
    send(16'hFFFF, 1'b0);
    repeat (4) @(negedge clock);
    reset_n = 1'b0;
    check_eq("rst_low_ready", 32'(rgb_ready), 32'd0);
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    @(negedge clock);
    check_eq("rst_abort_en", 32'(ycbcr_data_en), 32'd0);
    check_eq("rst_abort_ready", 32'(rgb_ready), 32'd1);
    repeat (6) @(negedge clock);
    check_eq("rst_abort_pending", 32'(exp_q.size()), 32'd0);
    pair(16'hF800, 16'h001F, 8'hAA, 8'h4D, 8'hB5, 8'h1D, 1'b0);

    start_cnt = byte_cnt;
    pend = 16'h0000;
    for (int i = 0; i < 1001; i++) begin
      px = 16'($urandom);
      repeat ($urandom_range(0, 3)) @(negedge clock);
      send(px, 1'b0);
      if (i % 2 == 0) pend = px;
      else push_model(pend, px);
    end
    @(negedge clock);
    flush = 1'b1;
    @(posedge clock);
    #1;
    flush = 1'b0;
    push_model(pend, pend);
    budget = 0;
    while (exp_q.size() != 0 && budget < 40) begin
      budget++;
      @(negedge clock);
    end
    repeat (4) @(negedge clock);
    check_eq("random_drain", 32'(exp_q.size()), 32'd0);
    check_eq("random_byte_count", 32'(byte_cnt - start_cnt), 32'd2004);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
